// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 16;

    // x0 is hard-wired zero; writes to it are never forwarded to the register file.
    localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] waddr;
        logic [REG_DATA_W-1:0] wdata;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// Multiplier result FIFO; exposes every slot's address and valid bit for hazard lookup.
module wb_fifo #(
    parameter int AW    = 5,
    parameter int DW    = 16,
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          arst_n,
    input  logic                          push,
    input  logic                          pop,
    input  logic [AW-1:0]                 push_addr,
    input  logic [DW-1:0]                 push_data,
    output logic [AW-1:0]                 head_addr,
    output logic [DW-1:0]                 head_data,
    output logic [$clog2(DEPTH):0]        count,
    output logic [DEPTH-1:0][AW-1:0]      entry_addr,
    output logic [DEPTH-1:0]              entry_valid
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0][AW-1:0] addr_reg;
    logic [DEPTH-1:0][DW-1:0] data_reg;
    logic [PW-1:0]            wr_ptr_reg;
    logic [PW-1:0]            rd_ptr_reg;
    logic [CW-1:0]            count_reg;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            addr_reg   <= '0;
            data_reg   <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                addr_reg[wr_ptr_reg] <= push_addr;
                data_reg[wr_ptr_reg] <= push_data;
                wr_ptr_reg           <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + CW'(push) - CW'(pop);
        end
    end

    assign head_addr  = addr_reg[rd_ptr_reg];
    assign head_data  = data_reg[rd_ptr_reg];
    assign count      = count_reg;
    assign entry_addr = addr_reg;

    // A slot is live when its distance from the read pointer is below the occupancy.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
            logic [PW-1:0] offs;
            assign offs            = PW'(gi) - rd_ptr_reg;
            assign entry_valid[gi] = ({1'b0, offs} < count_reg);
        end
    endgenerate

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Sole driver of the register-file write port: ALU stream first, then buffered
// multiplier results, then a same-cycle multiplier bypass when the FIFO is empty.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic                     alu_wen,
    input  logic [ADDR_W-1:0]        alu_waddr,
    input  logic [DATA_W-1:0]        alu_wdata,
    input  logic                     mul_valid,
    output logic                     mul_ready,
    input  logic [ADDR_W-1:0]        mul_waddr,
    input  logic [DATA_W-1:0]        mul_wdata,
    input  logic [ADDR_W-1:0]        raddr_1,
    input  logic [ADDR_W-1:0]        raddr_2,
    output logic                     busy_1,
    output logic                     busy_2,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     reg_write,
    output logic [ADDR_W-1:0]        waddr,
    output logic [DATA_W-1:0]        wdata
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [ADDR_W-1:0] X0 = ADDR_W'(REG_X0);

    logic                    push;
    logic                    pop;
    logic                    bypass;
    logic [ADDR_W-1:0]       head_addr;
    logic [DATA_W-1:0]       head_data;
    logic [DEPTH-1:0][ADDR_W-1:0] entry_addr;
    logic [DEPTH-1:0]        entry_valid;
    logic [DEPTH-1:0]        hit_1;
    logic [DEPTH-1:0]        hit_2;

    wb_fifo #(
        .AW    (ADDR_W),
        .DW    (DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .arst_n      (arst_n),
        .push        (push),
        .pop         (pop),
        .push_addr   (mul_waddr),
        .push_data   (mul_wdata),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .count       (count),
        .entry_addr  (entry_addr),
        .entry_valid (entry_valid)
    );

    // Registered-only ready: a pop in the same cycle does not free a full FIFO.
    assign mul_ready = (count != CW'(DEPTH));

    always_comb begin
        reg_write = 1'b0;
        waddr     = '0;
        wdata     = '0;
        pop       = 1'b0;
        bypass    = 1'b0;
        if (alu_wen) begin
            if (alu_waddr != X0) begin
                reg_write = 1'b1;
                waddr     = alu_waddr;
                wdata     = alu_wdata;
            end
        end else if (count != '0) begin
            // x0 results are never enqueued, so the head is always a real write.
            reg_write = 1'b1;
            waddr     = head_addr;
            wdata     = head_data;
            pop       = 1'b1;
        end else if (mul_valid) begin
            bypass = 1'b1;
            if (mul_waddr != X0) begin
                reg_write = 1'b1;
                waddr     = mul_waddr;
                wdata     = mul_wdata;
            end
        end
        push = mul_valid && mul_ready && (mul_waddr != X0) && !bypass;
    end

    // Conservative: a head leaving this cycle still counts as pending.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_busy
            assign hit_1[gi] = entry_valid[gi] && (entry_addr[gi] == raddr_1);
            assign hit_2[gi] = entry_valid[gi] && (entry_addr[gi] == raddr_2);
        end
    endgenerate

    assign busy_1 = (|hit_1) && (raddr_1 != X0);
    assign busy_2 = (|hit_2) && (raddr_2 != X0);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: bypass, FIFO fill/drain, x0 handling,
// simultaneous push/pop and asynchronous reset during a drain.
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              arst_n;
    logic              alu_wen;
    logic [ADDR_W-1:0] alu_waddr;
    logic [DATA_W-1:0] alu_wdata;
    logic              mul_valid;
    logic              mul_ready;
    logic [ADDR_W-1:0] mul_waddr;
    logic [DATA_W-1:0] mul_wdata;
    logic [ADDR_W-1:0] raddr_1;
    logic [ADDR_W-1:0] raddr_2;
    logic              busy_1;
    logic              busy_2;
    logic [2:0]        count;
    logic              reg_write;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    int total  = 0;
    int passed = 0;

    regfile_wb_arbiter #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .alu_wen   (alu_wen),
        .alu_waddr (alu_waddr),
        .alu_wdata (alu_wdata),
        .mul_valid (mul_valid),
        .mul_ready (mul_ready),
        .mul_waddr (mul_waddr),
        .mul_wdata (mul_wdata),
        .raddr_1   (raddr_1),
        .raddr_2   (raddr_2),
        .busy_1    (busy_1),
        .busy_2    (busy_2),
        .count     (count),
        .reg_write (reg_write),
        .waddr     (waddr),
        .wdata     (wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic set_alu(input logic en, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        alu_wen = en; alu_waddr = a; alu_wdata = d;
    endtask

    task automatic set_mul(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        mul_valid = v; mul_waddr = a; mul_wdata = d;
    endtask

    task automatic chk_wr(input string tag, input logic we, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d);
        chk({tag, ".reg_write"}, 32'(reg_write), 32'(we));
        chk({tag, ".waddr"}, 32'(waddr), 32'(a));
        chk({tag, ".wdata"}, 32'(wdata), 32'(d));
    endtask

    initial begin
        arst_n = 1'b0;
        set_alu(1'b0, '0, '0);
        set_mul(1'b0, '0, '0);
        raddr_1 = '0;
        raddr_2 = '0;

        // 1. reset state
        repeat (2) @(negedge clk);
        #1;
        chk_wr("reset", 1'b0, 5'd0, 16'h0000);
        chk("reset.mul_ready", 32'(mul_ready), 32'd1);
        chk("reset.count", 32'(count), 32'd0);
        chk("reset.busy_1", 32'(busy_1), 32'd0);
        chk("reset.busy_2", 32'(busy_2), 32'd0);
        arst_n = 1'b1;

        // 2. bypass with empty FIFO
        @(negedge clk);
        set_mul(1'b1, 5'd3, 16'h1234);
        #1;
        chk_wr("bypass", 1'b1, 5'd3, 16'h1234);
        @(negedge clk);
        set_mul(1'b0, '0, '0);
        #1;
        chk("bypass.count", 32'(count), 32'd0);
        chk("bypass.idle_we", 32'(reg_write), 32'd0);

        // 3. fill under continuous ALU traffic, then drain in order
        for (int a = 6; a <= 9; a++) begin
            @(negedge clk);
            set_alu(1'b1, 5'd5, 16'h5555);
            set_mul(1'b1, 5'(a), 16'(a) << 8);
            #1;
            chk("fill.count", 32'(count), 32'(a - 6));
            chk_wr("fill.alu", 1'b1, 5'd5, 16'h5555);
        end
        @(negedge clk);
        set_mul(1'b1, 5'd11, 16'h0B00);
        raddr_1 = 5'd7;
        raddr_2 = 5'd4;
        #1;
        chk("full.count", 32'(count), 32'd4);
        chk("full.mul_ready", 32'(mul_ready), 32'd0);
        chk("full.busy_1", 32'(busy_1), 32'd1);
        chk("full.busy_2", 32'(busy_2), 32'd0);
        @(negedge clk);
        set_alu(1'b0, '0, '0);
        set_mul(1'b0, '0, '0);
        raddr_1 = 5'd6;
        #1;
        chk("full.blocked_count", 32'(count), 32'd4);
        chk("drain.busy_head", 32'(busy_1), 32'd1);
        for (int a = 6; a <= 9; a++) begin
            if (a != 6) begin
                @(negedge clk);
                #1;
            end
            chk_wr("drain", 1'b1, 5'(a), 16'(a) << 8);
        end
        @(negedge clk);
        #1;
        chk("drain.count", 32'(count), 32'd0);
        chk("drain.idle_we", 32'(reg_write), 32'd0);
        chk("drain.busy_1", 32'(busy_1), 32'd0);

        // 4. x0 destinations never write; mul x0 handshake is accepted and dropped
        @(negedge clk);
        set_alu(1'b1, 5'd0, 16'hFFFF);
        set_mul(1'b1, 5'd0, 16'hBEEF);
        #1;
        chk_wr("x0.alu", 1'b0, 5'd0, 16'h0000);
        chk("x0.mul_ready", 32'(mul_ready), 32'd1);
        @(negedge clk);
        set_alu(1'b0, '0, '0);
        #1;
        chk("x0.count", 32'(count), 32'd0);
        chk("x0.bypass_we", 32'(reg_write), 32'd0);
        @(negedge clk);
        set_mul(1'b0, '0, '0);
        #1;
        chk("x0.count2", 32'(count), 32'd0);

        // 5. push and pop in the same cycle at count=2
        @(negedge clk);
        set_alu(1'b1, 5'd5, 16'h5555);
        set_mul(1'b1, 5'd12, 16'h0C00);
        @(negedge clk);
        set_mul(1'b1, 5'd13, 16'h0D00);
        @(negedge clk);
        set_alu(1'b0, '0, '0);
        set_mul(1'b1, 5'd10, 16'h0A00);
        #1;
        chk("pp.count_before", 32'(count), 32'd2);
        chk_wr("pp.head", 1'b1, 5'd12, 16'h0C00);
        @(negedge clk);
        set_mul(1'b0, '0, '0);
        #1;
        chk("pp.count_after", 32'(count), 32'd2);
        chk_wr("pp.second", 1'b1, 5'd13, 16'h0D00);
        @(negedge clk);
        #1;
        chk_wr("pp.last", 1'b1, 5'd10, 16'h0A00);
        @(negedge clk);
        #1;
        chk("pp.empty", 32'(count), 32'd0);

        // 6. asynchronous reset while draining three entries
        for (int a = 14; a <= 16; a++) begin
            @(negedge clk);
            set_alu(1'b1, 5'd5, 16'h5555);
            set_mul(1'b1, 5'(a), 16'(a) << 8);
        end
        @(negedge clk);
        set_alu(1'b0, '0, '0);
        set_mul(1'b0, '0, '0);
        raddr_1 = 5'd15;
        #1;
        chk("rst.count3", 32'(count), 32'd3);
        chk_wr("rst.head", 1'b1, 5'd14, 16'h0E00);
        chk("rst.busy_pre", 32'(busy_1), 32'd1);
        #2;
        arst_n = 1'b0;
        #1;
        chk("rst.count", 32'(count), 32'd0);
        chk_wr("rst.async", 1'b0, 5'd0, 16'h0000);
        chk("rst.busy_1", 32'(busy_1), 32'd0);
        chk("rst.mul_ready", 32'(mul_ready), 32'd1);
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("rst.no_stale_we", 32'(reg_write), 32'd0);
        chk("rst.count_after", 32'(count), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
